// File: rtl/idiv53_seq.sv
// Radix-2 restoring divider: Q = floor(A * 2^52 / B) over 105 quotient bits,
// one bit per clock, with leading-zero count, exact-remainder and divide-by-zero flags.
module idiv53_seq (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_ena,
    input  logic [52:0]   i_divident,
    input  logic [52:0]   i_divisor,
    output logic [104:0]  o_result,
    output logic [6:0]    o_lshift,
    output logic          o_rdy,
    output logic          o_overflow,
    output logic          o_zero_resid
);

    localparam int unsigned OP_W  = 53;
    localparam int unsigned Q_W   = 105;
    localparam int unsigned R_W   = 54;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_FINAL = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [Q_W-1:0]     q_q, q_d;
    logic [R_W-1:0]     rem_q, rem_d;
    logic [Q_W-1:0]     res_q, res_d;
    logic [CNT_W-1:0]   lsh_q, lsh_d;
    logic               rdy_q, rdy_d;
    logic               ovf_q, ovf_d;
    logic               zr_q, zr_d;
    logic [R_W-1:0]     trial;
    logic [R_W-1:0]     diff;

    // Leading zeros of the 105-bit quotient; 105 when it is all zero.
    function automatic logic [CNT_W-1:0] lzc105(input logic [Q_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = CNT_W'(Q_W);
        for (int i = 0; i < int'(Q_W); i++) begin
            if (v[i]) n = CNT_W'(int'(Q_W) - 1 - i);
        end
        return n;
    endfunction

    // State and result registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            lsh_q   <= '0;
            rdy_q   <= 1'b0;
            ovf_q   <= 1'b0;
            zr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            lsh_q   <= lsh_d;
            rdy_q   <= rdy_d;
            ovf_q   <= ovf_d;
            zr_q    <= zr_d;
        end
    end

    // Next-state logic; the dividend is consumed MSB first from a left-shifting copy of A,
    // whose zero fill supplies the 52 appended low bits of {A, 52'b0}.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        rem_d   = rem_q;
        res_d   = res_q;
        lsh_d   = lsh_q;
        rdy_d   = 1'b0;
        ovf_d   = ovf_q;
        zr_d    = zr_q;
        trial   = {rem_q[OP_W-1:0], a_q[OP_W-1]};
        diff    = trial - {1'b0, b_q};

        case (state_q)
            ST_IDLE: begin
                if (i_ena) begin
                    a_d     = i_divident;
                    b_d     = i_divisor;
                    q_d     = '0;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(Q_W - 1);
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                a_d = {a_q[OP_W-2:0], 1'b0};
                if (trial >= {1'b0, b_q}) begin
                    q_d   = {q_q[Q_W-2:0], 1'b1};
                    rem_d = diff;
                end else begin
                    q_d   = {q_q[Q_W-2:0], 1'b0};
                    rem_d = trial;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = ST_FINAL;
            end
            ST_FINAL: begin
                if (b_q == '0) begin
                    res_d = '1;
                    lsh_d = '0;
                    zr_d  = 1'b0;
                    ovf_d = 1'b1;
                end else begin
                    res_d = q_q;
                    lsh_d = lzc105(q_q);
                    zr_d  = (rem_q == '0);
                    ovf_d = 1'b0;
                end
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_result     = res_q;
    assign o_lshift     = lsh_q;
    assign o_rdy        = rdy_q;
    assign o_overflow   = ovf_q;
    assign o_zero_resid = zr_q;

endmodule

// File: tb/tb_idiv53_seq.sv
// Scoreboard bench for idiv53_seq: expected results from wide-integer division are queued
// at issue time and checked by an independent monitor on each o_rdy pulse.
module tb_idiv53_seq;

    typedef struct {
        logic [104:0] res;
        logic [6:0]   lsh;
        logic         ovf;
        logic         zr;
        int           issue;
    } exp_t;

    logic          clk;
    logic          nrst;
    logic          ena;
    logic [52:0]   a;
    logic [52:0]   b;
    logic [104:0]  o_result;
    logic [6:0]    o_lshift;
    logic          o_rdy;
    logic          o_overflow;
    logic          o_zero_resid;

    exp_t sb[$];
    exp_t last;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   prev_rdy = 1'b0;

    localparam logic [52:0] ONE = 53'h10000000000000;

    idiv53_seq dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_ena        (ena),
        .i_divident   (a),
        .i_divisor    (b),
        .o_result     (o_result),
        .o_lshift     (o_lshift),
        .o_rdy        (o_rdy),
        .o_overflow   (o_overflow),
        .o_zero_resid (o_zero_resid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [104:0] act, input logic [104:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain wide-integer division of A*2^52 by B.
    function automatic exp_t model(input logic [52:0] av, input logic [52:0] bv);
        exp_t e;
        logic [104:0] num, den, q, tmp;
        int lz;
        e.issue = 0;
        if (bv == 53'd0) begin
            e.res = {105{1'b1}};
            e.lsh = 7'd0;
            e.ovf = 1'b1;
            e.zr  = 1'b0;
        end else begin
            num   = {av, 52'd0};
            den   = {52'd0, bv};
            q     = num / den;
            e.res = q;
            e.ovf = 1'b0;
            e.zr  = ((num % den) == 105'd0);
            lz    = 105;
            tmp   = q;
            while (tmp != 105'd0) begin
                tmp = tmp >> 1;
                lz--;
            end
            e.lsh = 7'(lz);
        end
        return e;
    endfunction

    // Monitor: checks every o_rdy pulse against the queue, pulse width and output hold.
    always @(negedge clk) begin
        exp_t e;
        if (prev_rdy) begin
            chk("rdy_pulse_width", 105'(o_rdy), 105'd0);
            chk("hold_result", o_result, last.res);
            chk("hold_lshift", 105'(o_lshift), 105'(last.lsh));
        end
        if (o_rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_rdy", 105'(o_rdy), 105'd0);
            end else begin
                e = sb.pop_front();
                chk("result", o_result, e.res);
                chk("lshift", 105'(o_lshift), 105'(e.lsh));
                chk("overflow", 105'(o_overflow), 105'(e.ovf));
                chk("zero_resid", 105'(o_zero_resid), 105'(e.zr));
                chk("latency", 105'(cyc - e.issue), 105'd106);
                last = e;
            end
        end
        prev_rdy = o_rdy;
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_result"}, o_result, 105'd0);
        chk({tag, "_lshift"}, 105'(o_lshift), 105'd0);
        chk({tag, "_rdy"}, 105'(o_rdy), 105'd0);
        chk({tag, "_overflow"}, 105'(o_overflow), 105'd0);
        chk({tag, "_zero_resid"}, 105'(o_zero_resid), 105'd0);
    endtask

    function automatic logic [52:0] rnd53();
        return 53'({$urandom, $urandom});
    endfunction

    // Start one operation; operands are scrambled afterwards to prove they were latched.
    task automatic issue(input logic [52:0] av, input logic [52:0] bv);
        exp_t e;
        @(negedge clk);
        a   = av;
        b   = bv;
        ena = 1'b1;
        e       = model(av, bv);
        e.issue = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        ena = 1'b0;
        a   = rnd53();
        b   = rnd53();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("completion_timeout", 105'(sb.size()), 105'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_op(input logic [52:0] av, input logic [52:0] bv);
        issue(av, bv);
        wait_idle();
    endtask

    initial begin
        exp_t e;
        logic [52:0] ra, rb;
        int kind;

        nrst = 1'b0;
        ena  = 1'b0;
        a    = '0;
        b    = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        run_op(ONE, ONE);
        run_op(ONE, 53'h18000000000000);
        run_op(53'h1FFFFFFFFFFFFF, 53'd1);
        run_op(ONE, 53'd0);
        run_op(53'd0, 53'd3);

        // Start strobes during FINAL and mid-iteration must be ignored.
        @(negedge clk);
        a   = ONE;
        b   = ONE;
        ena = 1'b1;
        e       = model(ONE, ONE);
        e.issue = cyc + 1;
        sb.push_back(e);
        for (int n = 0; n < 110; n++) begin
            @(negedge clk);
            ena = (n == 4 || n == 105);
            b   = (n == 4 || n == 105) ? 53'd0 : rnd53();
        end
        ena = 1'b0;
        wait_idle();
        repeat (120) @(negedge clk);

        // Asynchronous reset during iteration aborts silently.
        issue(53'h1FFFFFFFFFFFFF, 53'd7);
        repeat (40) @(negedge clk);
        nrst = 1'b0;
        sb.delete();
        #1;
        check_zero_outputs("midop_reset");
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (120) @(negedge clk);
        run_op(ONE, ONE);

        for (int k = 0; k < 24; k++) begin
            kind = int'($urandom_range(0, 9));
            ra   = {1'b1, 52'(rnd53())};
            rb   = {1'b1, 52'(rnd53())};
            case (kind)
                0: rb = 53'd0;
                1: ra = 53'd0;
                2: rb = 53'($urandom_range(1, 255));
                3: ra = rnd53();
                4: rb = rnd53();
                5: rb = ra;
                default: ;
            endcase
            run_op(ra, rb);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
